mem_cmd_ctrl: RTL

- Command front-end sitting between the memory tester/traffic source and the 32x8 single-port memory.
- Accepts read/write commands over a valid/ready handshake and buffers them in a small command FIFO.
- Sequences each command onto the memory's read/write/addr/data_in/data_out pins with fixed timing, and returns read data with an address tag as a one-cycle response pulse.

---
 rtl/mem_cmd_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_cmd_ctrl.sv
// Command front-end for a single-port memory: buffers read/write commands in a FIFO and
// sequences them onto the memory pins. Define MEM_CTRL_STATS_EN to add wr_count/rd_count.
module mem_cmd_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_CAP} state_t;

  logic [ENTRY_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  state_t             r_state;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_data_in;
  logic               r_rsp_valid;
  logic [ADDR_W-1:0]  r_rsp_addr;
  logic [DATA_W-1:0]  r_rsp_data;

  logic               w_full;
  logic               w_cmd_ready;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic               w_head_write;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_data;

  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_cmd_ready  = !reset && !w_full;
  assign w_push       = cmd_valid && w_cmd_ready;
  // RD is the only state that cannot hand off to the next command.
  assign w_pop        = (r_state != ST_RD) && (r_count != '0);
  assign w_head       = r_fifo[r_rd_ptr];
  assign w_head_write = w_head[ENTRY_W-1];
  assign w_head_addr  = w_head[DATA_W +: ADDR_W];
  assign w_head_data  = w_head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_addr    <= '0;
      r_rsp_data    <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: r_state <= ST_IDLE;
        ST_WR: begin
          r_mem_write <= 1'b0;
          r_state     <= ST_IDLE;
        end
        ST_RD: begin
          r_mem_read <= 1'b0;
          r_state    <= ST_CAP;
        end
        ST_CAP: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= mem_data_out;
          r_rsp_addr  <= r_mem_addr;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // A pop dispatches the head command and overrides the exits chosen above.
      if (w_pop) begin
        r_mem_addr <= w_head_addr;
        if (w_head_write) begin
          r_mem_write   <= 1'b1;
          r_mem_read    <= 1'b0;
          r_mem_data_in <= w_head_data;
          r_state       <= ST_WR;
        end else begin
          r_mem_read  <= 1'b1;
          r_mem_write <= 1'b0;
          r_state     <= ST_RD;
        end
      end
    end
  end

`ifdef MEM_CTRL_STATS_EN
  logic [15:0] r_wr_count;
  logic [15:0] r_rd_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else begin
      if (r_mem_write && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
      if (r_rsp_valid && (r_rd_count != 16'hFFFF)) r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;
`endif

  assign cmd_ready   = w_cmd_ready;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_mem_addr;
  assign mem_data_in = r_mem_data_in;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_addr    = r_rsp_addr;
  assign rsp_data    = r_rsp_data;

endmodule
